// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I instruction-decode stage.
// Decodes instruction fields and immediates, owns the architectural register
// file (written from WB), and holds results in a single output register
// handed to EX over a valid/ready handshake with flush.
// Optional build macro: ID_BYPASS_EN (write-through bypass from WB into the
// operand capture on a load cycle).
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [RAW-1:0]  rs1,
    output logic [RAW-1:0]  rs2,
    output logic [RAW-1:0]  rd,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] pc_out
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // IF->ID: in_valid/in_ready, in_ready = !out_valid || out_ready (no skid
    // buffer, so ready depends combinationally on the downstream side).
    // ID->EX: out_valid/out_ready; while out_valid && !out_ready all outputs
    // hold. flush clears out_valid and drops any instruction offered alongside.

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0] regs [NREG];

    logic [RAW-1:0]  dec_rs1;
    logic [RAW-1:0]  dec_rs2;
    logic [RAW-1:0]  dec_rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            load;

    // Register indices are truncated to RAW bits for smaller register files.
    assign dec_rs1 = instr[15 +: RAW];
    assign dec_rs2 = instr[20 +: RAW];
    assign dec_rd  = instr[7 +: RAW];

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    // Build the 32-bit immediate per format; unknown opcodes give zero.
    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    // Sign-extend from bit 31 to the datapath width.
    assign dec_imm = XLEN'($signed(imm32));

    // Operand read; x0 is hard-wired to zero regardless of array contents.
    always_comb begin
        rd1 = (dec_rs1 == '0) ? '0 : regs[dec_rs1];
        rd2 = (dec_rs2 == '0) ? '0 : regs[dec_rs2];
`ifdef ID_BYPASS_EN
        if (wb_en && (wb_rd == dec_rs1) && (dec_rs1 != '0)) begin
            rd1 = wb_data;
        end
        if (wb_en && (wb_rd == dec_rs2) && (dec_rs2 != '0)) begin
            rd2 = wb_data;
        end
`endif
    end

    // Register file writeback, independent of the decode handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output pipeline register: flush beats load, load beats drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            imm       <= '0;
            opcode    <= '0;
            funct3    <= '0;
            funct7    <= '0;
            pc_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            rs1_data  <= rd1;
            rs2_data  <= rd2;
            rs1       <= dec_rs1;
            rs2       <= dec_rs2;
            rd        <= dec_rd;
            imm       <= dec_imm;
            opcode    <= instr[6:0];
            funct3    <= instr[14:12];
            funct7    <= instr[31:25];
            pc_out    <= pc_in;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage for the RV32I pipeline, sitting between IF and EX. It extracts instruction fields and generates immediates for all base formats (I/S/B/U/J). It owns the architectural register file, with a writeback port from WB. Results go into a skid-free output pipeline register using a valid/ready handshake, with flush support.

Parameters:
XLEN, 32, datapath / register / immediate width (>=32)
NREG, 32, number of architectural registers (power of 2, <=32)
RAW, 5, register address width (log2 NREG)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  IF presents valid instr/pc_in
in_ready  output  1  ID can accept this cycle
instr  input  32  instruction word
pc_in  input  XLEN  PC of instr
flush  input  1  kill output register contents and incoming instr
wb_en  input  1  register-file write enable
wb_rd  input  RAW  write address
wb_data  input  XLEN  write data
out_valid  output  1  decoded bundle valid
out_ready  input  1  EX accepts bundle
rs1_data  output  XLEN  operand 1
rs2_data  output  XLEN  operand 2
rs1  output  RAW  source register 1 index
rs2  output  RAW  source register 2 index
rd  output  RAW  destination register index
imm  output  XLEN  sign-extended immediate
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
pc_out  output  XLEN  registered pc_in

Behaviour:
- Reset (async, any cycle, including mid-stall): all outputs 0; out_valid=0; all register-file entries 0.
- in_ready = !out_valid || out_ready (combinational).
- Load: on a clk edge with in_valid && in_ready && !flush, the output register captures:
  - decoded fields, pc_out <= pc_in, out_valid <= 1.
  - Latency is 1 cycle.
- Drain: on a clk edge with out_valid && out_ready and no load, out_valid <= 0. Data outputs hold their values.
- Stall: out_valid && !out_ready holds all outputs stable, and in_ready=0.
- Flush: out_valid <= 0 next edge. Has priority over load; an instr offered in the same cycle is dropped. Data outputs are don't-care but hold their values.
- Field extraction: rd=instr[11:7], rs1=instr[19:15], rs2=instr[24:20]. When NREG<32, indices are truncated to RAW bits.
- Register read: rs1_data = (rs1==0) ? 0 : regfile[rs1]; same rule for rs2.
- Writeback: at the clk edge, when wb_en && wb_rd!=0, regfile[wb_rd] <= wb_data. Writes to x0 are ignored; x0 always reads 0.
- Writeback is independent of the handshake: it occurs during stall, flush or idle.
- Immediates are sign-extended from instr[31] to XLEN:
  - I (0010011, 0000011, 1100111, 1110011): instr[31:20]
  - S (0100011): {instr[31:25], instr[11:7]}
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - All other opcodes: imm=0.

Optional Feature:
ID_BYPASS_EN:
- Defined: write-through bypass. During a load cycle, if wb_en && wb_rd==rs1 && rs1!=0, rs1_data captures wb_data instead of the stale regfile value. Same rule for rs2.
- Undefined: no bypass. A same-cycle writeback is not visible; the regfile's old value is captured.

Test Plan:
- Reset, then WB writes x1=5 and x2=10. Then addi x3,x1,-1 (0xFFF08193) with out_ready=1 -> next cycle: out_valid=1, rs1=1, rs1_data=5, rd=3, imm=0xFFFFFFFF, pc_out=pc_in.
- sw x2,8(x1) (0x0020A423) -> imm=8, rs2_data=10. beq x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC. lui x5,0x12345 (0x123452B7) -> imm=0x12345000. jal x1,+2048 (0x001000EF) -> imm=0x00000800.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; outputs stable; the next instr is loaded only on the cycle after out_ready=1.
- flush=1 with in_valid=1 -> next cycle out_valid=0; the dropped instr never appears.
- WB writes x0=0xDEAD -> a later read of x0 gives 0. Same-cycle wb x1=0x77 with decode of rs1=1 -> rs1_data=0x77 with ID_BYPASS_EN defined, 5 without.
- Assert reset while stalled with out_valid=1 -> out_valid=0 and all outputs 0 immediately (asynchronous); regfile cleared (x1 reads 0).
